// File: rtl/match_output_if.sv
// Result stream from the match extractor to the result writer.
// Payload is {tar_row[8:0], tar_col[9:0], img_row[8:0], img_col[9:0]}.
interface match_output_if;
  localparam int unsigned DATA_W = 38;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  modport master (output out_valid, output out_data, input out_ready);
  modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/match_output.sv
// Post-match result extractor: scans the 4-lane matched and target memories group
// by group and streams (target, image) pairs whose distance beats the threshold.
module match_output #(
  parameter int unsigned TAR_GROUP_MAX = 512
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic [10:0]                      tar_kpt_num,
  input  logic [29:0]                      dist_thresh,
  output logic [$clog2(TAR_GROUP_MAX)-1:0] rd_addr,
  input  logic [48:0]                      matched_dout_0,
  input  logic [48:0]                      matched_dout_1,
  input  logic [48:0]                      matched_dout_2,
  input  logic [48:0]                      matched_dout_3,
  input  logic [18:0]                      tar_rc_0,
  input  logic [18:0]                      tar_rc_1,
  input  logic [18:0]                      tar_rc_2,
  input  logic [18:0]                      tar_rc_3,
  match_output_if.master                   res,
  output logic [10:0]                      match_count,
  output logic                             busy,
  output logic                             done
);
  localparam int unsigned AW = $clog2(TAR_GROUP_MAX);
  localparam int unsigned KW = 11;
  localparam int unsigned DW = 30;
  localparam int unsigned MW = 49;
  localparam int unsigned TW = 19;
  localparam int unsigned CW = AW + 3;
  localparam logic [DW-1:0] SENTINEL = '1;

  typedef enum logic [2:0] {S_IDLE, S_READ, S_LATCH, S_EMIT, S_DONE} state_t;

  state_t          state, state_nx;
  logic [1:0]      lane, lane_nx;
  logic [AW-1:0]   grp_nx;
  logic [KW-1:0]   kpt_q;
  logic [DW-1:0]   thresh_q;
  logic [MW-1:0]   m_q [4];
  logic [TW-1:0]   t_q [4];

  logic [MW-1:0]   cur_m;
  logic [TW-1:0]   cur_t;
  logic [KW-1:0]   idx;
  logic [KW:0]     idx_inc;
  logic [AW:0]     grp_inc;
  logic            qual, last_lane, more_grp, emit_hs;

  // rd_addr doubles as the group counter
  assign cur_m     = m_q[lane];
  assign cur_t     = t_q[lane];
  assign idx       = KW'({rd_addr, lane});
  assign idx_inc   = {1'b0, idx} + (KW+1)'(1);
  assign grp_inc   = {1'b0, rd_addr} + (AW+1)'(1);
  assign qual      = (idx < kpt_q) && (cur_m[DW-1:0] < thresh_q) && (cur_m[DW-1:0] != SENTINEL);
  assign last_lane = (lane == 2'd3) || (idx_inc >= {1'b0, kpt_q});
  assign more_grp  = {grp_inc, 2'b00} < CW'(kpt_q);
  assign emit_hs   = (state == S_EMIT) && qual && res.out_ready;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    lane_nx  = lane;
    grp_nx   = rd_addr;
    case (state)
      S_IDLE: begin
        if (start) begin
          lane_nx  = 2'd0;
          grp_nx   = '0;
          state_nx = (tar_kpt_num == '0) ? S_DONE : S_READ;
        end
      end
      S_READ:  state_nx = S_LATCH;
      S_LATCH: begin
        state_nx = S_EMIT;
        lane_nx  = 2'd0;
      end
      S_EMIT: begin
        // Non-qualifying lanes fall through without waiting on the consumer
        if (!qual || res.out_ready) begin
          if (last_lane) begin
            if (more_grp) begin
              grp_nx   = grp_inc[AW-1:0];
              state_nx = S_READ;
            end else begin
              state_nx = S_DONE;
            end
          end else begin
            lane_nx = lane + 2'd1;
          end
        end
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Stream outputs come only from the lane registers and the state
  always_comb begin
    res.out_valid = 1'b0;
    res.out_data  = '0;
    if (state == S_EMIT && qual) begin
      res.out_valid = 1'b1;
      res.out_data  = {cur_t, cur_m[MW-1:DW]};
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      lane        <= 2'd0;
      rd_addr     <= '0;
      kpt_q       <= '0;
      thresh_q    <= '0;
      match_count <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        m_q[i] <= '0;
        t_q[i] <= '0;
      end
    end else begin
      lane    <= lane_nx;
      rd_addr <= grp_nx;
      busy    <= (state_nx != S_IDLE);
      done    <= (state_nx == S_DONE);
      if (state == S_IDLE && start) begin
        kpt_q       <= tar_kpt_num;
        thresh_q    <= dist_thresh;
        match_count <= '0;
      end else if (emit_hs) begin
        match_count <= match_count + KW'(1);
      end
      if (state == S_LATCH) begin
        m_q[0] <= matched_dout_0;
        m_q[1] <= matched_dout_1;
        m_q[2] <= matched_dout_2;
        m_q[3] <= matched_dout_3;
        t_q[0] <= tar_rc_0;
        t_q[1] <= tar_rc_1;
        t_q[2] <= tar_rc_2;
        t_q[3] <= tar_rc_3;
      end
    end
  end
endmodule

// File: tb/tb_match_output.sv
// Directed bench for match_output: synchronous memory models, a negedge monitor
// collecting accepted results, and immediate-assertion checks per step.
module tb_match_output;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [10:0] tar_kpt_num = '0;
  logic [29:0] dist_thresh = '0;
  logic [8:0]  rd_addr;
  logic [48:0] md [4];
  logic [18:0] td [4];
  logic [10:0] match_count;
  logic        busy, done;

  match_output_if bus();

  match_output #(.TAR_GROUP_MAX(512)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .tar_kpt_num(tar_kpt_num), .dist_thresh(dist_thresh), .rd_addr(rd_addr),
    .matched_dout_0(md[0]), .matched_dout_1(md[1]), .matched_dout_2(md[2]), .matched_dout_3(md[3]),
    .tar_rc_0(td[0]), .tar_rc_1(td[1]), .tar_rc_2(td[2]), .tar_rc_3(td[3]),
    .res(bus), .match_count(match_count), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Per-keypoint coordinate pattern stored in the memories
  function automatic logic [8:0] f_ir(input int i); return 9'(i + 3); endfunction
  function automatic logic [9:0] f_ic(input int i); return 10'(i * 2 + 1); endfunction
  function automatic logic [8:0] f_tr(input int i); return 9'(i + 100); endfunction
  function automatic logic [9:0] f_tc(input int i); return 10'(i * 3 + 7); endfunction
  function automatic logic [37:0] exp_data(input int i);
    return {f_tr(i), f_tc(i), f_ir(i), f_ic(i)};
  endfunction

  logic [29:0] dist_mem [512][4];

  always @(posedge clk) begin
    for (int l = 0; l < 4; l++) begin
      md[l] <= {f_ir(int'(rd_addr) * 4 + l), f_ic(int'(rd_addr) * 4 + l), dist_mem[rd_addr][l]};
      td[l] <= {f_tr(int'(rd_addr) * 4 + l), f_tc(int'(rd_addr) * 4 + l)};
    end
  end

  logic [37:0] res_q[$];
  bit tracking = 1'b0;
  int cyc_rel, done_cnt, done_cyc, valid_cnt, max_addr;
  int checks = 0, failures = 0;

  always @(negedge clk) begin
    if (tracking) begin
      cyc_rel++;
      if (bus.out_valid && bus.out_ready) res_q.push_back(bus.out_data);
      if (bus.out_valid) valid_cnt++;
      if (done) begin
        if (done_cnt == 0) done_cyc = cyc_rel;
        done_cnt++;
      end
      if (int'(rd_addr) > max_addr) max_addr = int'(rd_addr);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [10:0] kpt, input logic [29:0] thr);
    @(negedge clk);
    tar_kpt_num = kpt;
    dist_thresh = thr;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    res_q.delete();
    cyc_rel = 0; done_cnt = 0; done_cyc = -1; valid_cnt = 0; max_addr = 0;
    tracking = 1'b1;
  endtask

  task automatic wait_done(input int max_cyc);
    int n = 0;
    while (done_cnt == 0 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", 64'(done_cnt != 0), 64'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_results(input string tag, input int idx_list[$]);
    chk({tag, "_count"}, 64'(res_q.size()), 64'(idx_list.size()));
    for (int i = 0; i < idx_list.size(); i++) begin
      logic [37:0] obs;
      obs = (i < res_q.size()) ? res_q[i] : 'x;
      chk($sformatf("%s_data%0d", tag, i), 64'(obs), 64'(exp_data(idx_list[i])));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_idx[$];
    int n;
    logic [37:0] held;

    for (int a = 0; a < 512; a++)
      for (int l = 0; l < 4; l++) dist_mem[a][l] = 30'd500;
    bus.out_ready = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_rd_addr", 64'(rd_addr), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_data", 64'(bus.out_data), 64'd0);
    chk("rst_match_count", 64'(match_count), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);

    // S1: two full groups, all pass, consumer always ready
    do_start(11'd8, 30'd1000);
    wait_done(40);
    exp_idx = {0, 1, 2, 3, 4, 5, 6, 7};
    chk_results("s1", exp_idx);
    chk("s1_match_count", 64'(match_count), 64'd8);
    chk("s1_done_cycle", 64'(done_cyc), 64'd13);
    chk("s1_done_pulses", 64'(done_cnt), 64'd1);
    chk("s1_busy_after", 64'(busy), 64'd0);

    // S2: partial last group
    do_start(11'd5, 30'd1000);
    wait_done(40);
    exp_idx = {0, 1, 2, 3, 4};
    chk_results("s2", exp_idx);
    chk("s2_match_count", 64'(match_count), 64'd5);
    chk("s2_max_addr", 64'(max_addr), 64'd1);

    // S3: threshold and sentinel filtering
    dist_mem[0][0] = 30'd999;
    dist_mem[0][1] = 30'd1000;
    dist_mem[0][2] = 30'h3FFFFFFF;
    dist_mem[0][3] = 30'd0;
    do_start(11'd4, 30'd1000);
    wait_done(40);
    exp_idx = {0, 3};
    chk_results("s3", exp_idx);
    chk("s3_match_count", 64'(match_count), 64'd2);
    for (int l = 0; l < 4; l++) dist_mem[0][l] = 30'd500;

    // S4: ten-cycle stall on the first result, with an ignored start
    bus.out_ready = 1'b0;
    do_start(11'd8, 30'd1000);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("s4_first_valid", 64'(bus.out_valid), 64'd1);
    held = bus.out_data;
    chk("s4_first_data", 64'(held), 64'(exp_data(0)));
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 4) begin
        start = 1'b1;
        tar_kpt_num = 11'd2;
      end else begin
        start = 1'b0;
      end
      chk($sformatf("s4_stall_valid%0d", k), 64'(bus.out_valid), 64'd1);
      chk($sformatf("s4_stall_data%0d", k), 64'(bus.out_data), 64'(exp_data(0)));
    end
    start = 1'b0;
    chk("s4_stall_count", 64'(match_count), 64'd0);
    bus.out_ready = 1'b1;
    wait_done(60);
    exp_idx = {0, 1, 2, 3, 4, 5, 6, 7};
    chk_results("s4", exp_idx);
    chk("s4_match_count", 64'(match_count), 64'd8);

    // S5: zero keypoints
    do_start(11'd0, 30'd1000);
    wait_done(10);
    chk("s5_done_cycle", 64'(done_cyc), 64'd1);
    chk("s5_valid_cnt", 64'(valid_cnt), 64'd0);
    chk("s5_match_count", 64'(match_count), 64'd0);

    // S6: reset during EMIT of group 3, then a fresh scan
    do_start(11'd32, 30'd1000);
    n = 0;
    while (!(rd_addr == 9'd3 && bus.out_valid) && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("s6_reached_g3", 64'(rd_addr == 9'd3 && bus.out_valid), 64'd1);
    rst_n = 1'b1;
    #1;
    chk("s6_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("s6_rst_data", 64'(bus.out_data), 64'd0);
    chk("s6_rst_count", 64'(match_count), 64'd0);
    chk("s6_rst_rd_addr", 64'(rd_addr), 64'd0);
    chk("s6_rst_busy", 64'(busy), 64'd0);
    chk("s6_rst_done", 64'(done), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("s6_no_done", 64'(done_cnt), 64'd0);
    do_start(11'd8, 30'd1000);
    wait_done(40);
    exp_idx = {0, 1, 2, 3, 4, 5, 6, 7};
    chk_results("s6", exp_idx);
    chk("s6_match_count", 64'(match_count), 64'd8);
    chk("s6_done_cycle", 64'(done_cyc), 64'd13);

    tracking = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/match_output.md
# match_output

Post-match result extractor. Starts when the matcher's `done` pulses. Scans the 4-bank matched memory and the target row/col memory group by group. Drops unused lanes and matches whose distance fails a threshold, and streams surviving (target, image) coordinate pairs over a valid/ready handshake to the result writer. It also reports the total number of accepted matches.

## Interface
- `TAR_GROUP_MAX`, default 512: maximum number of target groups; sets the `rd_addr` range.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous reset, active-high (asserted = 1). The port keeps the codebase name.
- `start` in 1: one-cycle pulse from the matcher's `done`. Ignored unless idle.
- `tar_kpt_num` in 11: number of target keypoints. Latched on an accepted `start`.
- `dist_thresh` in 30: distance threshold. Latched on an accepted `start`.
- `rd_addr` out 9: group address, shared by the matched-memory read port and the target memory.
- `matched_dout_0..3` in 49 each: matched entry per lane. Bits [48:40] are image row, [39:30] are image col, [29:0] are distance.
- `tar_rc_0..3` in 19 each: target keypoint per lane. Bits [18:10] are row, [9:0] are col.
- `out_valid` out 1: result available.
- `out_ready` in 1: consumer accepts the result.
- `out_data` out 38: {tar_row[8:0], tar_col[9:0], img_row[8:0], img_col[9:0]}.
- `match_count` out 11: number of accepted results since the last `start`.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when the scan is complete.

## Operation
- States: IDLE, READ, LATCH, EMIT, DONE.
- IDLE:
  - On `start`: latch `tar_kpt_num` and `dist_thresh`, clear `match_count` and the group counter, set lane = 0.
  - If `tar_kpt_num` == 0, go to DONE. Otherwise go to READ.
- READ: `rd_addr` = group counter. Both memories are synchronous with 1-cycle read latency. Next state is LATCH.
- LATCH: register all four `matched_dout_*` and `tar_rc_*` words into lane registers. Next state is EMIT, lane 0.
- EMIT, one lane at a time. A lane qualifies when all of the following hold:
  - group*4 + lane < `tar_kpt_num` (11-bit compare);
  - distance < `dist_thresh` (strict);
  - distance != 30'h3FFFFFFF (the no-match sentinel).
- EMIT, qualifying lane:
  - `out_valid` = 1 and `out_data` = the concatenation of that lane's fields.
  - The state holds until `out_valid` && `out_ready`.
  - On the handshake, `match_count` increments and the lane advances.
- EMIT, non-qualifying lane: skipped in one cycle with `out_valid` = 0.
- After lane 3, or after the last in-range lane of the final group:
  - more groups remain (group + 1 < ceil(`tar_kpt_num`/4)): increment the group counter and go to READ;
  - otherwise go to DONE.
- DONE: `done` = 1 for one cycle, then IDLE. `match_count` holds its value until the next accepted `start`.
- `start` while `busy` is ignored. Latched parameters are unaffected.
- `out_data` and `out_valid` are stable while waiting for `out_ready`. They are driven only from the lane registers and the state, never from the memory outputs.

## Timing
- Reset values: `rd_addr` = 0, `out_valid` = 0, `out_data` = 0, `match_count` = 0, `busy` = 0, `done` = 0, state = IDLE.
- Reset is asynchronous. Asserting it mid-scan clears all outputs immediately, discards the scan and returns to IDLE. No `done` is produced.
- Accepted `start` at cycle 0 gives READ at cycle 1 (`rd_addr` = 0), LATCH at cycle 2 and lane 0 in EMIT at cycle 3.
- Per group, with the consumer always ready: 2 + 4 cycles. With `tar_kpt_num` == 0, `done` is high at cycle 1.
- Partial last group: lanes at or beyond `tar_kpt_num` are never emitted. Advancement after the last in-range lane is immediate.
- Maximum run: `tar_kpt_num` = 2047 gives 512 groups, and `rd_addr` reaches 511 with no wrap. `match_count` saturates cannot occur, since its maximum is 2047.
- `out_ready` may be high with `out_valid` low; this has no effect. Back-pressure of any length is legal.

## Test plan
- Scenario 1: `tar_kpt_num` = 8, `dist_thresh` = 1000, all distances 500, `out_ready` = 1.
  - Required: 8 results in order lane 0..3 of group 0, then group 1.
  - Required: `match_count` = 8, and `done` at cycle 13.
- Scenario 2: `tar_kpt_num` = 5, all distances pass.
  - Required: 5 results; lanes 1..3 of group 1 are not emitted.
  - Required: `rd_addr` never exceeds 1.
- Scenario 3: one group; distances 999, 1000, 3FFFFFFF (the sentinel), 0; `dist_thresh` = 1000.
  - Required: only lanes 0 and 3 are emitted, and `match_count` = 2.
- Scenario 4: hold `out_ready` = 0 for 10 cycles on the first result.
  - Required: `out_data` and `out_valid` stay stable, and there is no lane advance.
  - Required: a `start` pulsed during the stall is ignored.
- Scenario 5: `tar_kpt_num` = 0.
  - Required: `done` one cycle after `start`, no `out_valid`, `match_count` = 0.
- Scenario 6: assert reset during EMIT of group 3.
  - Required: outputs return to their reset values immediately.
  - Required: a subsequent `start` performs a full fresh scan.
